// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM state codes,
// datapath select encodings, opcode/funct constants and the bit positions
// of the one-hot instruction class vector produced by instr_decode.
package mc_controller_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Next-PC select, shared with the fetch unit's PC mux
  localparam logic [2:0] PCSRC_PC4    = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_REG    = 3'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] WDSRC_ALU = 2'd0;
  localparam logic [1:0] WDSRC_DM  = 2'd1;
  localparam logic [1:0] WDSRC_PC4 = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Bit positions inside the one-hot instruction class vector
  localparam int unsigned CLS_ADDU  = 0;
  localparam int unsigned CLS_SUBU  = 1;
  localparam int unsigned CLS_ORI   = 2;
  localparam int unsigned CLS_LUI   = 3;
  localparam int unsigned CLS_LW    = 4;
  localparam int unsigned CLS_SW    = 5;
  localparam int unsigned CLS_BEQ   = 6;
  localparam int unsigned CLS_J     = 7;
  localparam int unsigned CLS_JAL   = 8;
  localparam int unsigned CLS_JR    = 9;
  localparam int unsigned CLS_OTHER = 10;
  localparam int unsigned CLS_W     = 11;

endpackage

// File: rtl/mc_controller_instr_decode.sv
// Combinational instruction classifier: maps the 32-bit instruction word to
// exactly one class bit. Anything not recognised (nop included) lands in
// CLS_OTHER so the FSM can retire it as a plain PC+4 step.
module instr_decode
  import mc_controller_pkg::*;
(
  input  logic [31:0]      i_instr,
  output logic [CLS_W-1:0] o_class
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_unused_fields;

  assign w_op            = i_instr[31:26];
  assign w_funct         = i_instr[5:0];
  // Register/immediate fields do not affect classification
  assign w_unused_fields = ^i_instr[25:6];

  // Classify on opcode, and on funct for R-type
  always_comb begin
    o_class = {CLS_W{1'b0}};
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU: o_class[CLS_ADDU]  = 1'b1;
          FN_SUBU: o_class[CLS_SUBU]  = 1'b1;
          FN_JR:   o_class[CLS_JR]    = 1'b1;
          default: o_class[CLS_OTHER] = 1'b1;
        endcase
      end
      OP_ORI:  o_class[CLS_ORI]   = 1'b1;
      OP_LUI:  o_class[CLS_LUI]   = 1'b1;
      OP_LW:   o_class[CLS_LW]    = 1'b1;
      OP_SW:   o_class[CLS_SW]    = 1'b1;
      OP_BEQ:  o_class[CLS_BEQ]   = 1'b1;
      OP_J:    o_class[CLS_J]     = 1'b1;
      OP_JAL:  o_class[CLS_JAL]   = 1'b1;
      default: o_class[CLS_OTHER] = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset controller. The state register is the only
// storage; every control output is a function of the current state and the
// held instruction (plus Zero for the beq PC select), so a reset that forces
// FETCH immediately silences every write enable of an interrupted instruction.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic [2:0]  PCSrc,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSrc,
  output logic        MemWrite,
  output logic        ALUSrcB,
  output logic [1:0]  ExtOp,
  output logic [2:0]  ALUCtrl,
  output logic [2:0]  State
);

  state_e           r_state;
  logic [CLS_W-1:0] w_class;
  logic             w_two_cycle;

  instr_decode u_instr_decode (
    .i_instr (Instr),
    .o_class (w_class)
  );

  // Jumps and unrecognised encodings finish in DECODE
  assign w_two_cycle = w_class[CLS_J] | w_class[CLS_JAL] |
                       w_class[CLS_JR] | w_class[CLS_OTHER];

  assign State = r_state;

  // State register: reset forces FETCH, illegal codes fall back to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH:  r_state <= ST_DECODE;
        ST_DECODE: r_state <= w_two_cycle ? ST_FETCH : ST_EXEC;
        ST_EXEC: begin
          if (w_class[CLS_LW] | w_class[CLS_SW]) begin
            r_state <= ST_MEM;
          end else if (w_class[CLS_BEQ]) begin
            r_state <= ST_FETCH;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM:    r_state <= w_class[CLS_LW] ? ST_WB : ST_FETCH;
        ST_WB:     r_state <= ST_FETCH;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

  // Per-state control outputs; anything not driven by the state stays 0
  always_comb begin
    PCSrc    = PCSRC_PC4;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = REGDST_RT;
    WDSrc    = WDSRC_ALU;
    MemWrite = 1'b0;
    ALUSrcB  = 1'b0;
    ExtOp    = EXT_ZERO;
    ALUCtrl  = ALU_ADD;
    case (r_state)
      ST_FETCH: begin
        IRWrite = 1'b1;
      end
      ST_DECODE: begin
        if (w_class[CLS_JAL]) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RA;
          WDSrc    = WDSRC_PC4;
          PCWrite  = 1'b1;
          PCSrc    = PCSRC_JUMP;
        end else if (w_class[CLS_J]) begin
          PCWrite  = 1'b1;
          PCSrc    = PCSRC_JUMP;
        end else if (w_class[CLS_JR]) begin
          PCWrite  = 1'b1;
          PCSrc    = PCSRC_REG;
        end else if (w_class[CLS_OTHER]) begin
          PCWrite  = 1'b1;
          PCSrc    = PCSRC_PC4;
        end else begin
          PCWrite  = 1'b0;
        end
      end
      ST_EXEC: begin
        if (w_class[CLS_SUBU] | w_class[CLS_BEQ]) begin
          ALUCtrl = ALU_SUB;
        end else if (w_class[CLS_ORI]) begin
          ALUCtrl = ALU_OR;
        end else begin
          ALUCtrl = ALU_ADD;
        end
        if (w_class[CLS_LW] | w_class[CLS_SW] | w_class[CLS_BEQ]) begin
          ExtOp = EXT_SIGN;
        end else if (w_class[CLS_LUI]) begin
          ExtOp = EXT_LUI;
        end else begin
          ExtOp = EXT_ZERO;
        end
        ALUSrcB = w_class[CLS_ORI] | w_class[CLS_LUI] |
                  w_class[CLS_LW]  | w_class[CLS_SW];
        if (w_class[CLS_BEQ]) begin
          PCWrite = 1'b1;
          PCSrc   = Zero ? PCSRC_BRANCH : PCSRC_PC4;
        end else begin
          PCWrite = 1'b0;
        end
      end
      ST_MEM: begin
        if (w_class[CLS_SW]) begin
          MemWrite = 1'b1;
          PCWrite  = 1'b1;
        end else begin
          MemWrite = 1'b0;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        RegDst   = (w_class[CLS_ADDU] | w_class[CLS_SUBU]) ? REGDST_RD : REGDST_RT;
        WDSrc    = w_class[CLS_LW] ? WDSRC_DM : WDSRC_ALU;
      end
      default: begin
        IRWrite = 1'b0;
      end
    endcase
  end

endmodule
